mode_record: RTL and testbench
==============================

# mode_record

Recording mode: captures what the player performs on the 7 note switches and octave selector, measures each note's duration in whole time units, and writes the result into a packed song buffer. The buffer uses exactly the note / duration / octave packing that the song library supplies to the learn and play modes, so a recorded tune can be replayed by the existing players. It sits beside `mode_learn` under the mode multiplexer and drives the buzzer path while recording.

## Interface
- `SONG_TIME`, 56: buffer entries, including the terminator slot.
- `TICKS_PER_UNIT`, 10000000: clock cycles per duration unit.
- `MAX_UNITS`, 15: saturation value of a 4-bit duration.

Ports:
- `clk` input 1: system clock. Single clock domain.
- `reset` input 1: synchronous, active-high.
- `switches` input 7: note keys; bit k selects note k+1.
- `octave_sel` input 2: 00 middle, 01 low, 10 high; 11 is treated as 00.
- `rec_start` input 1: level; its rising edge arms recording.
- `rec_stop` input 1: level; its rising edge ends recording.
- `song_packed` output SONG_TIME*4: note codes; entry i is at bits [4i+3:4i].
- `time_packed` output SONG_TIME*4: duration in units, packed the same way.
- `octave_packed` output SONG_TIME*2: octave per entry; entry i is at bits [2i+1:2i].
- `note_count` output 6: number of committed entries, excluding the terminator.
- `recording` output 1: high in the WAIT, NOTE and REST states.
- `full` output 1: high once the buffer is exhausted.
- `note_to_play` output 4: live note code for the buzzer.
- `octave_out` output 2: live octave for the buzzer.
- `led_out` output 7: one-hot LED for the live note; 0 for a rest.

## Operation
**Input conditioning**
- `switches`, `rec_start` and `rec_stop` pass through 2-flop synchronizers.
- `rec_start` and `rec_stop` edges are detected by comparison with their previous sampled value.

**Note decode**
- The lowest-index asserted switch wins: bit0 gives 1, …, bit6 gives 7.
- No switch asserted gives 0 (rest).
- The decoded pair (note, octave) is the current symbol. For a rest, the octave is 00.

**FSM states:** IDLE, WAIT, NOTE, REST, DONE.
- **IDLE / DONE**
  - A `rec_start` edge clears all buffer entries to 0 and clears `note_count`, then goes to WAIT.
  - A `rec_stop` edge is ignored.
- **WAIT**
  - Leading silence is not recorded.
  - The first non-rest symbol loads the held symbol, zeroes the tick and unit counters, and goes to NOTE.
- **NOTE / REST**
  - The tick counter runs from 0 to TICKS_PER_UNIT-1. On wrap, `units` increments, saturating at MAX_UNITS.
  - **Symbol change:** commit the held symbol with duration max(units,1), then load the new symbol.
    - The next state is REST if the new note is 0, otherwise NOTE.
    - Both counters restart at 0.
  - **Saturation:** when `units` reaches MAX_UNITS with the symbol unchanged, commit with 15 and restart the counters. The same symbol continues as a new entry.
- **Stop**
  - A `rec_stop` edge in NOTE commits the held note, then finalizes.
  - A `rec_stop` edge in REST drops the pending rest, then finalizes.
  - In WAIT it finalizes with `note_count`=0.
- **Finalize**
  - Write the terminator at index `note_count`: note 4'b1111, time 0, octave 00.
  - Go to DONE.
- **Commit**
  - Write `song[note_count]`, `time[note_count]` and `octave[note_count]`, then increment `note_count`.
  - If the increment makes `note_count` = SONG_TIME-1, finalize in the same cycle and set `full`.
  - Slot SONG_TIME-1 is always reserved for the terminator.
- **Live outputs**
  - In NOTE/REST, `note_to_play`, `octave_out` and `led_out` follow the held symbol.
  - Otherwise they are 0.

## Timing
- **Reset values:** state IDLE; all packed outputs 0; `note_count`=0; `recording`=0; `full`=0; live outputs 0.
- **Input latency:** a switch change reaches the decoder 2 cycles later. A commit occurs on the cycle after the decoder sees the change.
- **Start latency:** the buffer clear and WAIT entry happen 3 cycles after `rec_start` rises (2 sync + 1 edge).
- **Duration rule:** duration = floor(cycles held / TICKS_PER_UNIT), with a minimum of 1 and a maximum of 15.
- **Simultaneous events:**
  - A symbol change and a saturation in the same cycle: the change takes precedence (single commit).
  - A stop and a change in the same cycle: commit the old symbol, then finalize. The new symbol is discarded.
  - In IDLE/DONE with both edges present, start wins.
- **Reset mid-recording:** returns to IDLE with the buffer cleared. No terminator is written.
- **Output stability:** all outputs are registered. The packed buffers are stable except in commit and clear cycles.

## Structure
- **Shared package** `song_pkg`:
  - note codes MUSIC0–MUSIC7 and MUSIC_END=4'b1111;
  - octave codes MA=00, LO=01, HI=10;
  - SONG_TIME;
  - LED one-hot constants.
- **Sub-module** `input_sync_edge`: a 2-flop synchronizer with rising-edge output. It is instantiated once for `rec_start`, once for `rec_stop`, and once without edge detection for the 7-bit `switches` bus.
- The buffer is held in flops, not RAM, because it must support a whole-buffer clear in one cycle.

## Test plan
All scenarios use TICKS_PER_UNIT=4.
1. **Basic capture.** Start; note 3 middle for 10 cycles; note 5 high for 4 cycles; stop. Expect entries {3,2,00}, {5,1,10}, terminator at index 2, and `note_count`=2.
2. **Rests.** Start; 20 cycles of silence; note 1 low for 8 cycles; release for 6 cycles; note 2 for 4 cycles; stop. Expect no leading rest and entries {1,2,01}, {0,1,00}, {2,1,00}.
3. **Saturation.** Hold note 7 for 70 cycles, then stop. Expect {7,15}, {7,2} and `note_count`=2.
4. **Full buffer.** Alternate notes 1 and 2 for 60 changes. Expect `full`=1 after 55 commits, the terminator at index 55, and state DONE with further input ignored.
5. **Priority and minimum duration.** Set switches 7'b0010100 for 2 cycles, then stop. Expect {3,1}: lowest switch wins and the 1-unit minimum applies.
6. **Mid-recording reset.** Assert `reset` during NOTE. Expect every output back at its reset value. A following start/stop with no keys writes only the terminator at index 0.

Source files
------------

// File: rtl/song_pkg.sv
// song_pkg: note/octave codes, LED one-hot constants, song buffer geometry, FSM states and note decode shared by the song modes
package song_pkg;
  localparam int SONG_TIME = 56;
  localparam int MAX_UNITS = 15;
  localparam logic [3:0] MUSIC0 = 4'd0;
  localparam logic [3:0] MUSIC1 = 4'd1;
  localparam logic [3:0] MUSIC2 = 4'd2;
  localparam logic [3:0] MUSIC3 = 4'd3;
  localparam logic [3:0] MUSIC4 = 4'd4;
  localparam logic [3:0] MUSIC5 = 4'd5;
  localparam logic [3:0] MUSIC6 = 4'd6;
  localparam logic [3:0] MUSIC7 = 4'd7;
  localparam logic [3:0] MUSIC_END = 4'b1111;
  localparam logic [1:0] MA = 2'b00;
  localparam logic [1:0] LO = 2'b01;
  localparam logic [1:0] HI = 2'b10;
  localparam logic [6:0] LED_OFF = 7'b0000000;
  localparam logic [6:0] LED1 = 7'b0000001;
  localparam logic [6:0] LED2 = 7'b0000010;
  localparam logic [6:0] LED3 = 7'b0000100;
  localparam logic [6:0] LED4 = 7'b0001000;
  localparam logic [6:0] LED5 = 7'b0010000;
  localparam logic [6:0] LED6 = 7'b0100000;
  localparam logic [6:0] LED7 = 7'b1000000;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_NOTE, S_REST, S_DONE} state_t;
  typedef struct packed {
    logic [3:0] note;
    logic [1:0] oct;
  } sym_t;
  function automatic sym_t decode(input logic [6:0] sw, input logic [1:0] oct);
    sym_t s;
    s = '0;
    for (int k = 6; k >= 0; k--) if (sw[k]) s.note = 4'(k + 1);
    s.oct = (s.note == MUSIC0 || oct == 2'b11) ? MA : oct;
    return s;
  endfunction
  function automatic logic [6:0] led_of(input logic [3:0] note);
    return (note == MUSIC0 || note > MUSIC7) ? LED_OFF : LED1 << (note - 4'd1);
  endfunction
endpackage

// File: rtl/mode_record_if.sv
// mode_record_if: player inputs (switches, octave_sel, rec_start, rec_stop) and recorder outputs (packed song, status, live buzzer/LED)
interface mode_record_if;
  import song_pkg::*;
  logic [6:0] switches;
  logic [1:0] octave_sel;
  logic rec_start;
  logic rec_stop;
  logic [SONG_TIME*4-1:0] song_packed;
  logic [SONG_TIME*4-1:0] time_packed;
  logic [SONG_TIME*2-1:0] octave_packed;
  logic [5:0] note_count;
  logic recording;
  logic full;
  logic [3:0] note_to_play;
  logic [1:0] octave_out;
  logic [6:0] led_out;
  modport master (
    output switches, octave_sel, rec_start, rec_stop,
    input song_packed, time_packed, octave_packed, note_count, recording, full, note_to_play, octave_out, led_out
  );
  modport slave (
    input switches, octave_sel, rec_start, rec_stop,
    output song_packed, time_packed, octave_packed, note_count, recording, full, note_to_play, octave_out, led_out
  );
endinterface

// File: rtl/input_sync_edge.sv
// input_sync_edge: 2-flop synchronizer (clk, reset, d_i) giving q_o and, when EDGE, a rising-edge strobe rise_o
module input_sync_edge #(
  parameter int W = 1,
  parameter bit EDGE = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] rise_o
);
  logic [W-1:0] s1_q, s2_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end
  assign q_o = s2_q;
  if (EDGE) begin : g_edge
    logic [W-1:0] prev_q;
    always_ff @(posedge clk) prev_q <= reset ? '0 : s2_q;
    assign rise_o = s2_q & ~prev_q;
  end else begin : g_none
    assign rise_o = '0;
  end
endmodule

// File: rtl/mode_record.sv
// mode_record: records played notes with durations into the packed song buffer (clk, reset, bus: mode_record_if.slave)
module mode_record import song_pkg::*; #(
  parameter int TICKS_PER_UNIT = 10000000
) (
  input logic clk,
  input logic reset,
  mode_record_if.slave bus
);
  localparam int TW = $clog2(TICKS_PER_UNIT + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_UNIT - 1);
  localparam logic [5:0] LAST_SLOT = 6'(SONG_TIME - 1);
  localparam logic [3:0] UMAX = 4'(MAX_UNITS);
  logic [6:0] sw_s;
  logic start_e, stop_e;
  logic [8:0] sync_unused;
  input_sync_edge #(.W(1), .EDGE(1'b1)) u_start (.clk(clk), .reset(reset), .d_i(bus.rec_start), .q_o(sync_unused[0]), .rise_o(start_e));
  input_sync_edge #(.W(1), .EDGE(1'b1)) u_stop (.clk(clk), .reset(reset), .d_i(bus.rec_stop), .q_o(sync_unused[1]), .rise_o(stop_e));
  input_sync_edge #(.W(7), .EDGE(1'b0)) u_sw (.clk(clk), .reset(reset), .d_i(bus.switches), .q_o(sw_s), .rise_o(sync_unused[8:2]));
  state_t state_q, state_d;
  sym_t held_q, held_d, sym_c;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0] units_q, units_d, eff, dur;
  logic [SONG_TIME*4-1:0] song_q, song_d, time_q, time_d;
  logic [SONG_TIME*2-1:0] oct_q, oct_d;
  logic [5:0] count_q, count_d;
  logic full_q, full_d, rec_q, rec_d;
  logic [3:0] play_q, play_d;
  logic [1:0] poct_q, poct_d;
  logic [6:0] led_q, led_d;
  logic wrap, changed, sat, in_play, do_clear, do_commit, fin, load, adv, live;
  always_comb begin
    sym_c = decode(sw_s, bus.octave_sel);
    wrap = tick_q == TICK_LAST;
    // eff includes the unit completing on this edge, so the edge ending a hold still counts
    eff = (wrap && units_q != UMAX) ? units_q + 4'd1 : units_q;
    dur = (eff == 4'd0) ? 4'd1 : eff;
    changed = sym_c != held_q;
    sat = wrap && eff == UMAX;
    in_play = state_q == S_NOTE || state_q == S_REST;
    do_clear = (state_q == S_IDLE || state_q == S_DONE) && start_e;
    // a pending rest is dropped on stop; a pending note is kept
    do_commit = in_play && (stop_e ? state_q == S_NOTE : (changed || sat));
    load = !stop_e && (state_q == S_WAIT ? sym_c.note != MUSIC0 : in_play && changed);
    adv = in_play && !stop_e && !changed && !sat;
    tick_d = (adv && !wrap) ? tick_q + TW'(1) : '0;
    units_d = adv ? eff : 4'd0;
    held_d = load ? sym_c : held_q;
    state_d = load ? (sym_c.note == MUSIC0 ? S_REST : S_NOTE) : state_q;
    song_d = song_q;
    time_d = time_q;
    oct_d = oct_q;
    count_d = count_q;
    full_d = full_q;
    if (do_clear) begin
      song_d = '0;
      time_d = '0;
      oct_d = '0;
      count_d = '0;
      full_d = 1'b0;
      state_d = S_WAIT;
    end
    if (do_commit) begin
      song_d[4*int'(count_q) +: 4] = held_q.note;
      time_d[4*int'(count_q) +: 4] = dur;
      oct_d[2*int'(count_q) +: 2] = held_q.oct;
      count_d = count_q + 6'd1;
    end
    // the last slot is reserved, so reaching it ends the recording on the spot
    if (do_commit && count_d == LAST_SLOT) full_d = 1'b1;
    fin = ((state_q == S_WAIT || in_play) && stop_e) || (do_commit && count_d == LAST_SLOT);
    if (fin) begin
      song_d[4*int'(count_d) +: 4] = MUSIC_END;
      time_d[4*int'(count_d) +: 4] = 4'd0;
      oct_d[2*int'(count_d) +: 2] = MA;
      state_d = S_DONE;
    end
    rec_d = state_d == S_WAIT || state_d == S_NOTE || state_d == S_REST;
    live = state_d == S_NOTE || state_d == S_REST;
    play_d = live ? held_d.note : MUSIC0;
    poct_d = live ? held_d.oct : MA;
    led_d = live ? led_of(held_d.note) : LED_OFF;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      held_q <= '0;
      tick_q <= '0;
      units_q <= '0;
      song_q <= '0;
      time_q <= '0;
      oct_q <= '0;
      count_q <= '0;
      full_q <= 1'b0;
      rec_q <= 1'b0;
      play_q <= '0;
      poct_q <= '0;
      led_q <= '0;
    end else begin
      state_q <= state_d;
      held_q <= held_d;
      tick_q <= tick_d;
      units_q <= units_d;
      song_q <= song_d;
      time_q <= time_d;
      oct_q <= oct_d;
      count_q <= count_d;
      full_q <= full_d;
      rec_q <= rec_d;
      play_q <= play_d;
      poct_q <= poct_d;
      led_q <= led_d;
    end
  end
  assign bus.song_packed = song_q;
  assign bus.time_packed = time_q;
  assign bus.octave_packed = oct_q;
  assign bus.note_count = count_q;
  assign bus.full = full_q;
  assign bus.recording = rec_q;
  assign bus.note_to_play = play_q;
  assign bus.octave_out = poct_q;
  assign bus.led_out = led_q;
endmodule

// File: tb/tb_mode_record.sv
// tb_mode_record: directed scoreboard bench for mode_record with TICKS_PER_UNIT=4
module tb_mode_record;
  import song_pkg::*;
  typedef struct {
    logic [3:0] n;
    logic [3:0] t;
    logic [1:0] o;
  } ent_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] oct_req = 2'b00;
  logic [1:0] oct_p1 = 2'b00;
  ent_t exp_q[$];
  int checks = 0;
  int errors = 0;
  mode_record_if bus();
  mode_record #(.TICKS_PER_UNIT(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  // octave follows the same two-cycle lag as the synchronized switches so both reach the decoder together
  always @(posedge clk) begin
    oct_p1 <= oct_req;
    bus.octave_sel <= oct_p1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic hold(input logic [6:0] sw, input logic [1:0] o, input int n);
    bus.switches = sw;
    oct_req = o;
    step(n);
  endtask
  task automatic push(input logic [3:0] n, input logic [3:0] t, input logic [1:0] o);
    ent_t e;
    e.n = n;
    e.t = t;
    e.o = o;
    exp_q.push_back(e);
  endtask
  task automatic reset_values(input string tag);
    chk({tag, "_rec"}, 32'(bus.recording), 0);
    chk({tag, "_full"}, 32'(bus.full), 0);
    chk({tag, "_cnt"}, 32'(bus.note_count), 0);
    chk({tag, "_song"}, 32'(bus.song_packed != '0), 0);
    chk({tag, "_time"}, 32'(bus.time_packed != '0), 0);
    chk({tag, "_oct"}, 32'(bus.octave_packed != '0), 0);
    chk({tag, "_play"}, 32'(bus.note_to_play), 0);
    chk({tag, "_poct"}, 32'(bus.octave_out), 0);
    chk({tag, "_led"}, 32'(bus.led_out), 0);
  endtask
  task automatic start_rec();
    exp_q.delete();
    bus.rec_start = 1'b1;
    step(1);
    bus.rec_start = 1'b0;
    step(2);
    chk("rec_on", 32'(bus.recording), 1);
    chk("cnt_clr", 32'(bus.note_count), 0);
  endtask
  task automatic stop_rec(input logic want_full);
    int n;
    ent_t e;
    bus.switches = '0;
    oct_req = 2'b00;
    bus.rec_stop = 1'b1;
    step(1);
    bus.rec_stop = 1'b0;
    step(3);
    chk("rec_off", 32'(bus.recording), 0);
    chk("full", 32'(bus.full), 32'(want_full));
    chk("play_off", 32'(bus.note_to_play), 0);
    n = exp_q.size();
    chk("count", 32'(bus.note_count), n);
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("note%0d", i), 32'(bus.song_packed[4*i +: 4]), 32'(e.n));
      chk($sformatf("time%0d", i), 32'(bus.time_packed[4*i +: 4]), 32'(e.t));
      chk($sformatf("oct%0d", i), 32'(bus.octave_packed[2*i +: 2]), 32'(e.o));
    end
    chk("term_note", 32'(bus.song_packed[4*n +: 4]), 32'(MUSIC_END));
    chk("term_time", 32'(bus.time_packed[4*n +: 4]), 0);
    chk("term_oct", 32'(bus.octave_packed[2*n +: 2]), 0);
  endtask
  initial begin
    bus.switches = '0;
    bus.rec_start = 1'b0;
    bus.rec_stop = 1'b0;
    step(3);
    reset_values("rst");
    reset = 1'b0;
    step(2);
    // basic capture
    start_rec();
    hold(7'b0000000, MA, 3);
    hold(7'b0000100, MA, 4);
    chk("live3_note", 32'(bus.note_to_play), 3);
    chk("live3_led", 32'(bus.led_out), 32'(LED3));
    step(6);
    hold(7'b0010000, HI, 4);
    chk("live5_note", 32'(bus.note_to_play), 5);
    chk("live5_oct", 32'(bus.octave_out), 32'(HI));
    chk("live5_led", 32'(bus.led_out), 32'(LED5));
    push(4'd3, 4'd2, MA);
    push(4'd5, 4'd1, HI);
    stop_rec(1'b0);
    // rests and no leading silence
    start_rec();
    hold(7'b0000000, MA, 20);
    hold(7'b0000001, LO, 8);
    hold(7'b0000000, MA, 6);
    chk("rest_led", 32'(bus.led_out), 0);
    hold(7'b0000010, MA, 4);
    push(4'd1, 4'd2, LO);
    push(4'd0, 4'd1, MA);
    push(4'd2, 4'd1, MA);
    stop_rec(1'b0);
    // saturation splits a long note
    start_rec();
    hold(7'b1000000, MA, 70);
    push(4'd7, 4'd15, MA);
    push(4'd7, 4'd2, MA);
    stop_rec(1'b0);
    // full buffer
    start_rec();
    for (int i = 0; i < 60; i++) hold((i % 2) ? 7'b0000010 : 7'b0000001, MA, 4);
    for (int i = 0; i < 55; i++) push((i % 2) ? 4'd2 : 4'd1, 4'd1, MA);
    stop_rec(1'b1);
    // priority and minimum duration, plus clear of stale entries
    start_rec();
    hold(7'b0010100, MA, 2);
    push(4'd3, 4'd1, MA);
    stop_rec(1'b0);
    chk("clr_note2", 32'(bus.song_packed[11:8]), 0);
    chk("clr_time2", 32'(bus.time_packed[11:8]), 0);
    // reset mid-recording
    start_rec();
    hold(7'b0000001, MA, 6);
    chk("pre_rst_note", 32'(bus.note_to_play), 1);
    bus.switches = '0;
    reset = 1'b1;
    step(1);
    reset_values("midrst");
    reset = 1'b0;
    step(2);
    start_rec();
    stop_rec(1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
